muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port DB_IN, input, 26, databus value to be loaded.
REQ-004 SHALL have port DB_OUT, output, 26, PQ result driven toward the databus.
REQ-005 SHALL have port DB_OE, output, 1, databus drive enable for DB_OUT.
REQ-006 SHALL have ports LDX, LDY, LDZ, input, 1 each, load X (multiplicand/divisor), Y (multiplier), Z (dividend) from DB_IN.
REQ-007 SHALL have port MD_START, input, 1, start operation.
REQ-008 SHALL have port IS_DIV, input, 1, sampled with MD_START: 1 = divide, 0 = multiply.
REQ-009 SHALL have port MD_RST, input, 1, synchronous abort/clear.
REQ-010 SHALL have port OUTPUT_PQ, input, 1, request to place PQ on databus.
REQ-011 SHALL have port MD_IS_ACTIVE, output, 1, operation in progress.
REQ-012 SHALL have port DIV_ZERO, output, 1, last divide had zero divisor.

Function
REQ-013 SHALL treat X, Y, Z, PQ as 26-bit two's-complement integers.
REQ-014 SHALL implement states IDLE, SETUP, ITER, FIX.
REQ-015 In IDLE, LDX/LDY/LDZ SHALL each capture DB_IN at the clock edge; several asserted together all load.
REQ-016 In IDLE, MD_START=1 SHALL latch IS_DIV and go to SETUP; loads in that same cycle complete first and are used by the operation.
REQ-017 SETUP (1 cycle) SHALL latch operand magnitudes and result sign (XOR of operand signs), clear iteration counter to 0.
REQ-018 ITER SHALL process exactly one operand bit per cycle for 26 cycles (counter 0..25), shift-add for multiply, restoring shift-subtract for divide.
REQ-019 FIX (1 cycle) SHALL apply sign correction, write PQ, return to IDLE.
REQ-020 MD_IS_ACTIVE SHALL be 1 in SETUP, ITER, FIX: exactly 28 cycles per operation; PQ valid the first cycle it falls.
REQ-021 Multiply SHALL give PQ = bits [25:0] of the exact signed product (upper bits discarded).
REQ-022 Divide SHALL give PQ = Z / X truncated toward zero; remainder discarded.
REQ-023 Divide with X=0 SHALL still take 28 cycles, give PQ = 26'h1FFFFFF and set DIV_ZERO=1; any completed multiply or valid divide clears DIV_ZERO.
REQ-024 Divide -2^25 / -1 SHALL give PQ = 26'h2000000 (wrapped), DIV_ZERO=0.
REQ-025 While MD_IS_ACTIVE=1, LDX/LDY/LDZ/MD_START SHALL be ignored; X, Y, Z SHALL remain unchanged.
REQ-026 MD_RST=1 in any state SHALL, at the next edge, go to IDLE, clear PQ, DIV_ZERO and iteration state; X, Y, Z retained; MD_RST has priority over MD_START and loads.
REQ-027 DB_OE SHALL equal OUTPUT_PQ AND NOT MD_IS_ACTIVE, combinationally; DB_OUT SHALL be PQ when DB_OE=1, else 0.
REQ-028 A new MD_START in the same cycle FIX completes SHALL be ignored; accepted from the following IDLE cycle.

Reset
REQ-029 nRST=0 SHALL immediately, independent of CLK, force IDLE and X=Y=Z=PQ=0, DIV_ZERO=0, MD_IS_ACTIVE=0, DB_OE=0, DB_OUT=0.
REQ-030 nRST assertion mid-operation SHALL discard the operation; after release the block accepts MD_START on the first edge.

Verification
REQ-031 Load X=3, Y=-5; MD_START, IS_DIV=0 -> MD_IS_ACTIVE high 28 cycles, PQ=26'h3FFFFF1 (-15), DIV_ZERO=0.
REQ-032 Load Z=100, X=-7; divide -> PQ=26'h3FFFFF2 (-14); repeat Z=-100, X=7 -> same; Z=6, X=7 -> PQ=0.
REQ-033 Load Z=5, X=0; divide -> PQ=26'h1FFFFFF, DIV_ZERO=1; then multiply 2*2 -> PQ=4, DIV_ZERO=0.
REQ-034 Start multiply, assert LDX with DB_IN=9 and MD_START at cycle 10 -> both ignored, result uses original X; MD_RST at cycle 15 -> next cycle MD_IS_ACTIVE=0, PQ=0.
REQ-035 OUTPUT_PQ held high across an operation -> DB_OE=0 while active, DB_OE=1 with DB_OUT=PQ once MD_IS_ACTIVE falls.
REQ-036 Assert nRST mid-ITER with no clock edge -> all outputs 0 at once; X, Y, Z read back 0 via a subsequent multiply giving PQ=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 26-bit signed multiply/divide sequencer, one operand bit per cycle, 28 cycles per operation
module muldiv_sequencer (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [25:0] DB_IN,
    output logic [25:0] DB_OUT,
    output logic        DB_OE,
    input  logic        LDX,
    input  logic        LDY,
    input  logic        LDZ,
    input  logic        MD_START,
    input  logic        IS_DIV,
    input  logic        MD_RST,
    input  logic        OUTPUT_PQ,
    output logic        MD_IS_ACTIVE,
    output logic        DIV_ZERO
);
    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;
    state_t      state_q, state_d;
    logic [25:0] x_q, x_d, y_q, y_d, z_q, z_d, pq_q, pq_d, op_q, op_d;
    logic [51:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d, neg_q, neg_d, dz_q, dz_d, active_q, active_d;
    logic [25:0] abs_x, abs_a, res;
    logic [26:0] trial, diff, sum;

    // acc holds {high product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        abs_x    = x_q[25] ? -x_q : x_q;
        abs_a    = is_div_q ? (z_q[25] ? -z_q : z_q) : (y_q[25] ? -y_q : y_q);
        trial    = acc_q[51:25];
        diff     = trial - {1'b0, op_q};
        sum      = {1'b0, acc_q[51:26]} + (acc_q[0] ? {1'b0, op_q} : 27'd0);
        res      = neg_q ? -acc_q[25:0] : acc_q[25:0];
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        pq_d     = pq_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        if (MD_RST) begin
            state_d = IDLE;
            pq_d    = '0;
            dz_d    = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    x_d = LDX ? DB_IN : x_q;
                    y_d = LDY ? DB_IN : y_q;
                    z_d = LDZ ? DB_IN : z_q;
                    if (MD_START) begin
                        is_div_d = IS_DIV;
                        state_d  = SETUP;
                    end
                end
                SETUP: begin
                    op_d    = abs_x;
                    acc_d   = {26'd0, abs_a};
                    neg_d   = x_q[25] ^ (is_div_q ? z_q[25] : y_q[25]);
                    cnt_d   = '0;
                    state_d = ITER;
                end
                ITER: begin
                    acc_d   = is_div_q ? (trial >= {1'b0, op_q} ? {diff[25:0], acc_q[24:0], 1'b1}
                                                               : {acc_q[50:0], 1'b0})
                                       : {sum, acc_q[25:1]};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd25) ? FIX : ITER;
                end
                default: begin
                    pq_d    = (is_div_q && x_q == '0) ? 26'h1FFFFFF : res;
                    dz_d    = is_div_q && x_q == '0;
                    state_d = IDLE;
                end
            endcase
        end
        active_d = state_d != IDLE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            pq_q     <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            pq_q     <= pq_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            active_q <= active_d;
        end
    end

    assign MD_IS_ACTIVE = active_q;
    assign DIV_ZERO     = dz_q;
    assign DB_OE        = OUTPUT_PQ & ~active_q & nRST;
    assign DB_OUT       = DB_OE ? pq_q : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against an arithmetic reference model
module tb_muldiv_sequencer;
    logic        CLK = 1'b0, nRST, LDX, LDY, LDZ, MD_START, IS_DIV, MD_RST, OUTPUT_PQ;
    logic [25:0] DB_IN, DB_OUT;
    logic        DB_OE, MD_IS_ACTIVE, DIV_ZERO;
    logic [25:0] mx, my, mz;
    int          passed = 0, failed = 0, total = 0, n;

    muldiv_sequencer dut (
        .CLK(CLK), .nRST(nRST), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .LDX(LDX), .LDY(LDY), .LDZ(LDZ), .MD_START(MD_START), .IS_DIV(IS_DIV),
        .MD_RST(MD_RST), .OUTPUT_PQ(OUTPUT_PQ), .MD_IS_ACTIVE(MD_IS_ACTIVE), .DIV_ZERO(DIV_ZERO)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [25:0] ref_op(input bit div, input logic [25:0] x, y, z);
        longint sx, sy, sz, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sz = longint'($signed(z));
        if (div) begin
            if (x == 26'd0) return 26'h1FFFFFF;
            r = sz / sx;
        end else r = sx * sy;
        return r[25:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input bit lx, input bit ly, input bit lz, input logic [25:0] v);
        LDX = lx; LDY = ly; LDZ = lz; DB_IN = v;
        @(posedge CLK); #1;
        LDX = 0; LDY = 0; LDZ = 0;
        if (lx) mx = v;
        if (ly) my = v;
        if (lz) mz = v;
    endtask

    // kind 1: load X=9 plus MD_START, kind 2: MD_RST, kind 3: MD_START; applied in active cycle inj_at
    task automatic run(input bit div, input int inj_at, input int kind, output int cnt);
        IS_DIV = div; MD_START = 1;
        @(posedge CLK); #1;
        MD_START = 0;
        cnt = 0;
        while (MD_IS_ACTIVE === 1'b1 && cnt < 60) begin
            cnt++;
            if (cnt == 5) chk("oe_while_active", DB_OE, 0);
            if (cnt == inj_at) begin
                case (kind)
                    1: begin LDX = 1; DB_IN = 26'd9; MD_START = 1; end
                    2: MD_RST = 1;
                    3: MD_START = 1;
                    default: ;
                endcase
            end
            @(posedge CLK); #1;
            LDX = 0; MD_START = 0; MD_RST = 0;
        end
    endtask

    task automatic op(input string tag, input bit div);
        int c;
        run(div, 0, 0, c);
        chk({tag, " cycles"}, c, 28);
        chk({tag, " pq"}, DB_OUT, ref_op(div, mx, my, mz));
        chk({tag, " div_zero"}, DIV_ZERO, (div && mx == 26'd0) ? 1 : 0);
        chk({tag, " oe"}, DB_OE, 1);
    endtask

    initial begin
        nRST = 0; LDX = 0; LDY = 0; LDZ = 0; MD_START = 0; IS_DIV = 0; MD_RST = 0;
        OUTPUT_PQ = 1; DB_IN = '0; mx = '0; my = '0; mz = '0;
        #12;
        chk("rst active", MD_IS_ACTIVE, 0);
        chk("rst oe", DB_OE, 0);
        chk("rst out", DB_OUT, 0);
        chk("rst dz", DIV_ZERO, 0);
        @(posedge CLK); #1;
        nRST = 1;
        ld(1, 0, 0, 26'd3); ld(0, 1, 0, 26'h3FFFFFB);
        op("mul 3*-5", 0);
        chk("mul 3*-5 const", DB_OUT, 26'h3FFFFF1);
        ld(0, 0, 1, 26'd100); ld(1, 0, 0, 26'h3FFFFF9);
        op("div 100/-7", 1);
        chk("div 100/-7 const", DB_OUT, 26'h3FFFFF2);
        ld(0, 0, 1, 26'h3FFFF9C); ld(1, 0, 0, 26'd7);
        op("div -100/7", 1);
        ld(0, 0, 1, 26'd6);
        op("div 6/7", 1);
        chk("div 6/7 const", DB_OUT, 0);
        ld(0, 0, 1, 26'd5); ld(1, 0, 0, 26'd0);
        op("div by zero", 1);
        chk("div by zero dz", DIV_ZERO, 1);
        ld(1, 0, 0, 26'd2); ld(0, 1, 0, 26'd2);
        op("mul 2*2", 0);
        chk("mul 2*2 const", DB_OUT, 4);
        ld(0, 0, 1, 26'h2000000); ld(1, 0, 0, 26'h3FFFFFF);
        op("div min/-1", 1);
        chk("div min/-1 const", DB_OUT, 26'h2000000);
        ld(1, 1, 0, 26'd6);
        run(0, 10, 1, n);
        chk("ignore ld/start cycles", n, 28);
        chk("ignore ld/start pq", DB_OUT, 36);
        run(0, 15, 2, n);
        chk("md_rst cycles", n, 15);
        chk("md_rst pq", DB_OUT, 0);
        chk("md_rst dz", DIV_ZERO, 0);
        op("x kept after md_rst", 0);
        run(0, 28, 3, n);
        chk("start in fix cycles", n, 28);
        chk("start in fix idle", MD_IS_ACTIVE, 0);
        chk("start in fix pq", DB_OUT, 36);
        for (int i = 0; i < 14; i++) begin
            logic [25:0] a, b, c;
            a = (i % 5 == 0) ? 26'd0 : (i % 3 == 0) ? 26'($urandom_range(1, 50)) : 26'($urandom);
            b = (i % 2 == 0) ? 26'($urandom_range(0, 40)) : 26'($urandom);
            c = 26'($urandom);
            ld(1, 0, 0, a); ld(0, 1, 0, b); ld(0, 0, 1, c);
            op("random", i % 2 == 1 || a == 26'd0);
        end
        ld(0, 0, 1, 26'd5); ld(1, 0, 0, 26'd0);
        op("pre-reset div0", 1);
        ld(1, 0, 0, 26'd3); ld(0, 1, 0, 26'd4);
        IS_DIV = 0; MD_START = 1;
        @(posedge CLK); #1;
        MD_START = 0;
        repeat (8) @(posedge CLK);
        #3;
        nRST = 0;
        #1;
        chk("async rst active", MD_IS_ACTIVE, 0);
        chk("async rst oe", DB_OE, 0);
        chk("async rst out", DB_OUT, 0);
        chk("async rst dz", DIV_ZERO, 0);
        @(posedge CLK); #1;
        nRST = 1;
        mx = '0; my = '0; mz = '0;
        op("post-reset mul", 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
